alu_seq_param: RTL and testbench
================================

// Module: alu_seq_param
// PURPOSE
//  Parametrised, clocked successor to the 8-bit combinational ALU. It keeps the same 16-op
//  select encoding and adds the following:
//   - WIDTH-generic operands
//   - valid/ready handshakes on input and output
//   - iterative multi-cycle MUL and DIV
//   - status flags
//  It sits between an operand-issuing controller and a result consumer. Only one op is in flight.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; must be >= 4
//  SHW     $clog2(WIDTH)   shift-amount width (derived; do not override)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      A, B and select are valid
//  in_ready   out  1      block can accept an op
//  A          in   WIDTH  operand A (unsigned; ADD/SUB overflow treats it as two's complement)
//  B          in   WIDTH  operand B
//  select     in   4      opcode, encoded as below
//  out_valid  out  1      result and flags are valid
//  out_ready  in   1      consumer accepts the result
//  ALU_out    out  WIDTH  primary result
//  ALU_hi     out  WIDTH  MUL high half / DIV remainder; 0 for all other ops
//  flag_z     out  1      ALU_out == 0
//  flag_c     out  1      ADD carry-out / SUB borrow (A<B); 0 for all other ops
//  flag_v     out  1      ADD/SUB signed overflow; MUL: ALU_hi != 0; 0 otherwise
//  flag_dz    out  1      divide by zero (DIV with B == 0)
// BEHAVIOUR
//  Opcodes:
//   0 ADD   1 SUB   2 MUL   3 DIV   4 SHL   5 SHR   6 ROL   7 ROR
//   8 AND   9 OR    A XOR   B NOR   C NAND  D XNOR  E GT    F EQ
//  Width and operand rules:
//  - ADD/SUB are mod 2^WIDTH.
//  - MUL is the full 2*WIDTH product: low half on ALU_out, high half on ALU_hi.
//  - DIV gives the quotient on ALU_out and the remainder on ALU_hi.
//  - Shift/rotate amount is B[SHW-1:0]. SHL/SHR zero-fill. An amount of 0 passes A through.
//  - GT/EQ return {WIDTH-1 zeros, (A>B) / (A==B)}, unsigned compare.
//  FSM (states IDLE, BUSY, DONE):
//  - in_ready = (state == IDLE); it is combinational from state.
//  - IDLE: an op is accepted on the edge where in_valid && in_ready. A, B and select are captured.
//   - Ops other than MUL/DIV, and DIV with B == 0: the result is registered -> DONE.
//   - MUL/DIV with B != 0: -> BUSY, with the iteration counter set to WIDTH.
//  - BUSY:
//   - MUL: one shift-add step per cycle.
//   - DIV: one restoring-division step per cycle.
//   - The counter decrements each cycle. When it reaches 0 the result is registered -> DONE.
//  - DONE: out_valid = 1. The outputs are held stable while out_ready = 0.
//   - When out_valid && out_ready: -> IDLE. out_valid falls on the next cycle.
//  Latency, counted from the accept edge to the first cycle with out_valid high:
//  - Single-cycle ops: 1 cycle.
//  - MUL/DIV: WIDTH+1 cycles.
//  - Throughput: at most one op per 2 cycles. No new op is accepted in BUSY or DONE.
//  Divide by zero:
//  - ALU_out = all ones, ALU_hi = A, flag_dz = 1, flag_v = 0.
//  - Completes with 1-cycle latency and never enters BUSY.
//  Flags are registered together with ALU_out. flag_dz = 0 for every op except DIV with B == 0.
//  Input changes while not accepting are ignored. Captured operands are not affected by later
//  input changes.
//  Reset:
//  - state = IDLE. in_ready = 1 in the first cycle after reset.
//  - out_valid = 0; ALU_out, ALU_hi and all flags = 0; counter = 0.
//  - Reset during BUSY or DONE aborts the op. No result is emitted.
//  - Reset has priority over every handshake.
//  Undefined select values are impossible because all 16 codes are defined.
// TESTING  (WIDTH=8 unless noted)
//  1. A=125, B=5, sweep ops 0..F, out_ready=1 -> results and latencies:
//     - ADD=130, c=0, v=1. SUB=120, c=0, v=0.
//     - MUL: ALU_out=113, ALU_hi=2, v=1. DIV: ALU_out=25, ALU_hi=0.
//     - SHL (B=5): 160. SHR: 3.
//     - GT=1, EQ=0.
//     - Latency is 1 cycle for all ops except MUL/DIV, which take 9 cycles.
//  2. A=10, B=0, DIV -> ALU_out=255, ALU_hi=10, dz=1, 1-cycle latency.
//     The next op (ADD 1+1) -> 2, dz=0.
//  3. Back-pressure: ADD 200+100 with out_ready=0 for 5 cycles:
//     - ALU_out=44, c=1, v=0, held stable throughout. in_ready=0 throughout.
//     - Result is accepted on the first cycle out_ready=1. in_ready=1 on the next cycle.
//  4. Reset asserted 3 cycles into a MUL -> out_valid never rises. On the cycle after reset,
//     outputs are 0 and in_ready=1. A following SUB 5-7 -> 254, c=1.
//  5. Rotates: A=8'h81, B=1 -> ROL=8'h03, ROR=8'hC0. B=8 (amount 0) -> A unchanged.
//  6. WIDTH=16 build: MUL 300*300 -> ALU_out=24464, ALU_hi=1, 17-cycle latency.
//     Random ops are checked against a reference model.

Source files
------------

// File: rtl/alu_seq_param.sv
// alu_seq_param: WIDTH-generic clocked ALU with valid/ready handshakes,
// iterative MUL/DIV and status flags; one op in flight at a time.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (A, B, select captured on accept)
//   out_valid/out_ready result handshake (ALU_out, ALU_hi, flags held in DONE)
//   ALU_out, ALU_hi     primary result; MUL high half / DIV remainder
//   flag_z/c/v/dz       zero, carry/borrow, overflow, divide-by-zero
module alu_seq_param #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_out,
    output logic [WIDTH-1:0] ALU_hi,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_dz
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;

    logic [CW-1:0]    cnt;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] b_r;
    // MUL: hi_r = partial product high half, lo_r = multiplier/product low half.
    // DIV: hi_r = partial remainder, lo_r = dividend shifting into quotient.
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // ---------------- single-cycle datapath (operates on live inputs) ----
    logic [SHW-1:0]   amt;
    logic [31:0]      amt_inv;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_hi;
    logic             r_c;
    logic             r_v;
    logic             r_dz;

    assign amt     = B[SHW-1:0];
    assign amt_inv = 32'(WIDTH) - 32'(amt);
    assign sum     = {1'b0, A} + {1'b0, B};
    // Bit WIDTH of the widened difference is the borrow (A < B).
    assign diff    = {1'b0, A} - {1'b0, B};

    always_comb begin
        r_out = '0;
        r_hi  = '0;
        r_c   = 1'b0;
        r_v   = 1'b0;
        r_dz  = 1'b0;
        unique case (select)
            OP_ADD: begin
                r_out = sum[WIDTH-1:0];
                r_c   = sum[WIDTH];
                r_v   = (A[WIDTH-1] == B[WIDTH-1]) &&
                        (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                r_out = diff[WIDTH-1:0];
                r_c   = diff[WIDTH];
                r_v   = (A[WIDTH-1] != B[WIDTH-1]) &&
                        (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_MUL: r_out = '0;
            // Only reached here for B == 0; non-zero divisors iterate.
            OP_DIV: begin
                r_out = '1;
                r_hi  = A;
                r_dz  = 1'b1;
            end
            OP_SHL:  r_out = A << amt;
            OP_SHR:  r_out = A >> amt;
            // Shift by WIDTH yields 0, so amount 0 passes A through.
            OP_ROL:  r_out = (A << amt) | (A >> amt_inv);
            OP_ROR:  r_out = (A >> amt) | (A << amt_inv);
            OP_AND:  r_out = A & B;
            OP_OR:   r_out = A | B;
            OP_XOR:  r_out = A ^ B;
            OP_NOR:  r_out = ~(A | B);
            OP_NAND: r_out = ~(A & B);
            OP_XNOR: r_out = ~(A ^ B);
            OP_GT:   r_out = {{(WIDTH-1){1'b0}}, (A > B)};
            OP_EQ:   r_out = {{(WIDTH-1){1'b0}}, (A == B)};
        endcase
    end

    // ---------------- iterative step (operates on captured state) --------
    logic             is_div;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_tr;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign is_div  = (op_r == OP_DIV);
    assign mul_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : '0);
    assign div_sh  = {hi_r, lo_r[WIDTH-1]};
    // Negative trial (bit WIDTH set) means restore: keep the shifted value.
    assign div_tr  = div_sh - {1'b0, b_r};

    always_comb begin
        if (is_div) begin
            step_hi = div_tr[WIDTH] ? div_sh[WIDTH-1:0] : div_tr[WIDTH-1:0];
            step_lo = {lo_r[WIDTH-2:0], ~div_tr[WIDTH]};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_r[WIDTH-1:1]};
        end
    end

    // ---------------- control FSM and result registers --------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op_r    <= '0;
            b_r     <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            ALU_out <= '0;
            ALU_hi  <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            flag_dz <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r <= select;
                        b_r  <= B;
                        lo_r <= A;
                        hi_r <= '0;
                        if (select == OP_MUL ||
                            (select == OP_DIV && B != '0)) begin
                            cnt   <= CW'(WIDTH);
                            state <= BUSY;
                        end else begin
                            ALU_out <= r_out;
                            ALU_hi  <= r_hi;
                            flag_z  <= (r_out == '0);
                            flag_c  <= r_c;
                            flag_v  <= r_v;
                            flag_dz <= r_dz;
                            state   <= DONE;
                        end
                    end
                end
                BUSY: begin
                    hi_r <= step_hi;
                    lo_r <= step_lo;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        ALU_out <= step_lo;
                        ALU_hi  <= step_hi;
                        flag_z  <= (step_lo == '0);
                        flag_c  <= 1'b0;
                        flag_v  <= !is_div && (step_hi != '0);
                        flag_dz <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_param.sv
// tb_alu_seq_param: directed and random checks of alu_seq_param at
// WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_alu_seq_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       iv8, ir8, ov8, ordy8, z8, c8, v8, dz8;
    logic [7:0] a8, b8, o8, h8;
    logic [3:0] s8;

    logic        iv16, ir16, ov16, ordy16, z16, c16, v16, dz16;
    logic [15:0] a16, b16, o16, h16;
    logic [3:0]  s16;

    alu_seq_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .select(s8), .out_valid(ov8),
        .out_ready(ordy8), .ALU_out(o8), .ALU_hi(h8),
        .flag_z(z8), .flag_c(c8), .flag_v(v8), .flag_dz(dz8)
    );

    alu_seq_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .A(a16), .B(b16), .select(s16), .out_valid(ov16),
        .out_ready(ordy16), .ALU_out(o16), .ALU_hi(h16),
        .flag_z(z16), .flag_c(c16), .flag_v(v16), .flag_dz(dz16)
    );

    int n_vec = 0;
    int n_err = 0;

    longint e_out[2], e_hi[2];
    bit     e_z[2], e_c[2], e_v[2], e_dz[2];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic longint sx(input longint x, input int w);
        return (x >= (64'(1) << (w - 1))) ? x - (64'(1) << w) : x;
    endfunction

    // Reference model: plain integer arithmetic on the opcode meaning.
    task automatic model(input int w, input longint a, input longint b,
                         input int sel, output longint o, output longint h,
                         output bit z, output bit c, output bit v,
                         output bit dz, output int lat);
        longint m, s, sr, half;
        int amt;
        m    = (64'(1) << w) - 1;
        half = 64'(1) << (w - 1);
        amt  = int'(b % w);
        o = 0; h = 0; c = 0; v = 0; dz = 0;
        case (sel)
            0: begin
                s = a + b; o = s & m; c = (s >> w) != 0;
                sr = sx(a, w) + sx(b, w); v = (sr >= half) || (sr < -half);
            end
            1: begin
                o = (a - b) & m; c = a < b;
                sr = sx(a, w) - sx(b, w); v = (sr >= half) || (sr < -half);
            end
            2: begin s = a * b; o = s & m; h = s >> w; v = h != 0; end
            3: begin
                if (b == 0) begin o = m; h = a; dz = 1; end
                else begin o = a / b; h = a % b; end
            end
            4: o = (a << amt) & m;
            5: o = a >> amt;
            6: o = ((a << amt) | (a >> (w - amt))) & m;
            7: o = ((a >> amt) | (a << (w - amt))) & m;
            8: o = a & b;
            9: o = a | b;
            10: o = a ^ b;
            11: o = ~(a | b) & m;
            12: o = ~(a & b) & m;
            13: o = ~(a ^ b) & m;
            14: o = (a > b) ? 1 : 0;
            default: o = (a == b) ? 1 : 0;
        endcase
        z   = (o == 0);
        lat = (sel == 2 || (sel == 3 && b != 0)) ? w + 1 : 1;
    endtask

    // Compare process: every cycle a result is presented it must match
    // the model and the input side must be closed.
    always @(negedge clk) begin
        if (!rst) begin
            if (ov8) begin
                chk("w8_out", 64'(o8), e_out[0]);
                chk("w8_hi", 64'(h8), e_hi[0]);
                chk("w8_z", 64'(z8), 64'(e_z[0]));
                chk("w8_c", 64'(c8), 64'(e_c[0]));
                chk("w8_v", 64'(v8), 64'(e_v[0]));
                chk("w8_dz", 64'(dz8), 64'(e_dz[0]));
                chk("w8_in_ready_done", 64'(ir8), 0);
            end
            if (ov16) begin
                chk("w16_out", 64'(o16), e_out[1]);
                chk("w16_hi", 64'(h16), e_hi[1]);
                chk("w16_z", 64'(z16), 64'(e_z[1]));
                chk("w16_c", 64'(c16), 64'(e_c[1]));
                chk("w16_v", 64'(v16), 64'(e_v[1]));
                chk("w16_dz", 64'(dz16), 64'(e_dz[1]));
                chk("w16_in_ready_done", 64'(ir16), 0);
            end
        end
    end

    task automatic do_op(input int d, input longint a, input longint b,
                         input int sel, input int stall,
                         output longint ro, output longint rh,
                         output bit rc, output bit rv, output bit rdz,
                         output int lat);
        int  elat;
        bit  got;
        logic ov;
        model(d ? 16 : 8, a, b, sel, e_out[d], e_hi[d], e_z[d], e_c[d],
              e_v[d], e_dz[d], elat);
        ro = 0; rh = 0; rc = 0; rv = 0; rdz = 0;
        @(negedge clk);
        chk("in_ready_idle", d ? 64'(ir16) : 64'(ir8), 1);
        if (d == 0) begin
            iv8 = 1; a8 = a[7:0]; b8 = b[7:0]; s8 = sel[3:0];
            ordy8 = (stall == 0);
        end else begin
            iv16 = 1; a16 = a[15:0]; b16 = b[15:0]; s16 = sel[3:0];
            ordy16 = (stall == 0);
        end
        @(posedge clk);
        #1;
        if (d == 0) begin
            iv8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 4'($urandom);
        end else begin
            iv16 = 0; a16 = 16'($urandom); b16 = 16'($urandom);
            s16 = 4'($urandom);
        end
        lat = 0;
        got = 0;
        while (!got && lat < 64) begin
            @(negedge clk);
            lat++;
            ov = d ? ov16 : ov8;
            if (ov) got = 1;
        end
        if (!got) begin
            chk("out_valid_timeout", 0, 1);
            return;
        end
        chk("latency", 64'(lat), 64'(elat));
        ro  = d ? longint'(o16) : longint'(o8);
        rh  = d ? longint'(h16) : longint'(h8);
        rc  = d ? c16 : c8;
        rv  = d ? v16 : v8;
        rdz = d ? dz16 : dz8;
        repeat (stall) @(negedge clk);
        if (d == 0) ordy8 = 1; else ordy16 = 1;
        @(negedge clk);
        chk("out_valid_drop", d ? 64'(ov16) : 64'(ov8), 0);
        chk("in_ready_back", d ? 64'(ir16) : 64'(ir8), 1);
    endtask

    longint r_o[16], r_h[16];
    bit     r_c[16], r_v[16], r_dz[16];
    int     r_lat[16];
    longint qo, qh;
    bit     qc, qv, qdz;
    int     ql;

    initial begin
        iv8 = 0; a8 = 0; b8 = 0; s8 = 0; ordy8 = 1;
        iv16 = 0; a16 = 0; b16 = 0; s16 = 0; ordy16 = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("rst_in_ready", 64'(ir8), 1);
        chk("rst_out_valid", 64'(ov8), 0);
        chk("rst_out", 64'(o8), 0);
        chk("rst_hi", 64'(h8), 0);
        chk("rst_flags", 64'({z8, c8, v8, dz8}), 0);
        chk("rst16_in_ready", 64'(ir16), 1);

        // Op sweep with A=125, B=5
        for (int s = 0; s < 16; s++)
            do_op(0, 125, 5, s, 0, r_o[s], r_h[s], r_c[s], r_v[s],
                  r_dz[s], r_lat[s]);
        chk("add", r_o[0], 130);
        chk("add_c", 64'(r_c[0]), 0);
        chk("add_v", 64'(r_v[0]), 1);
        chk("sub", r_o[1], 120);
        chk("sub_c", 64'(r_c[1]), 0);
        chk("sub_v", 64'(r_v[1]), 0);
        chk("mul_lo", r_o[2], 113);
        chk("mul_hi", r_h[2], 2);
        chk("mul_v", 64'(r_v[2]), 1);
        chk("div_q", r_o[3], 25);
        chk("div_r", r_h[3], 0);
        chk("shl", r_o[4], 160);
        chk("shr", r_o[5], 3);
        chk("gt", r_o[14], 1);
        chk("eq", r_o[15], 0);
        chk("lat_add", 64'(r_lat[0]), 1);
        chk("lat_mul", 64'(r_lat[2]), 9);
        chk("lat_div", 64'(r_lat[3]), 9);
        chk("lat_xnor", 64'(r_lat[13]), 1);

        // Divide by zero, then a clean op
        do_op(0, 10, 0, 3, 0, qo, qh, qc, qv, qdz, ql);
        chk("dz_out", qo, 255);
        chk("dz_hi", qh, 10);
        chk("dz_flag", 64'(qdz), 1);
        chk("dz_v", 64'(qv), 0);
        chk("dz_lat", 64'(ql), 1);
        do_op(0, 1, 1, 0, 0, qo, qh, qc, qv, qdz, ql);
        chk("after_dz_add", qo, 2);
        chk("after_dz_flag", 64'(qdz), 0);

        // Back-pressure
        do_op(0, 200, 100, 0, 5, qo, qh, qc, qv, qdz, ql);
        chk("bp_out", qo, 44);
        chk("bp_c", 64'(qc), 1);
        chk("bp_v", 64'(qv), 0);

        // Reset aborts a MUL three cycles in
        @(negedge clk);
        iv8 = 1; a8 = 8'd7; b8 = 8'd9; s8 = 4'd2; ordy8 = 1;
        @(posedge clk);
        #1 iv8 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort_in_ready", 64'(ir8), 1);
        chk("abort_out", 64'(o8), 0);
        chk("abort_hi", 64'(h8), 0);
        chk("abort_flags", 64'({z8, c8, v8, dz8}), 0);
        for (int i = 0; i < 12; i++) begin
            chk("abort_no_valid", 64'(ov8), 0);
            @(negedge clk);
        end
        do_op(0, 5, 7, 1, 0, qo, qh, qc, qv, qdz, ql);
        chk("post_abort_sub", qo, 254);
        chk("post_abort_c", 64'(qc), 1);

        // Rotates
        do_op(0, 'h81, 1, 6, 0, qo, qh, qc, qv, qdz, ql);
        chk("rol1", qo, 'h03);
        do_op(0, 'h81, 1, 7, 0, qo, qh, qc, qv, qdz, ql);
        chk("ror1", qo, 'hC0);
        do_op(0, 'h81, 8, 6, 0, qo, qh, qc, qv, qdz, ql);
        chk("rol0", qo, 'h81);
        do_op(0, 'h81, 8, 7, 0, qo, qh, qc, qv, qdz, ql);
        chk("ror0", qo, 'h81);

        // WIDTH=16 multiply
        do_op(1, 300, 300, 2, 0, qo, qh, qc, qv, qdz, ql);
        chk("w16_mul_lo", qo, 24464);
        chk("w16_mul_hi", qh, 1);
        chk("w16_mul_lat", 64'(ql), 17);

        // Random ops on both widths
        for (int i = 0; i < 60; i++) begin
            int     d, sel;
            longint a, b;
            d   = i % 2;
            a   = d ? longint'($urandom_range(0, 65535))
                    : longint'($urandom_range(0, 255));
            b   = d ? longint'($urandom_range(0, 65535))
                    : longint'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) b = 0;
            sel = $urandom_range(0, 15);
            do_op(d, a, b, sel, $urandom_range(0, 2),
                  qo, qh, qc, qv, qdz, ql);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
